// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard FSM states and register-index width.
package cpu_types_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, HALT} hazard_state_t;
  typedef logic [4:0] regbits_t;
endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in ID/EX whose destination feeds the instruction in IF/ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_rt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     loaduse
);
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign loaduse = ex_dREN && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
endmodule

// File: rtl/pipeline_control.sv
// Pipeline latch enable/flush generation, halt/data-wait tracking, stall counter and watchdog.
//  state | meaning
//  RUN   | normal issue; hazards resolved per cycle
//  DWAIT | data access outstanding in MEM; whole pipe frozen
//  HALT  | halt retired; everything frozen until reset
module pipeline_control
  import cpu_types_pkg::*;
#(
  parameter int CNTW    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_dREN,
  input  logic            mem_dWEN,
  input  logic            mem_redirect,
  input  logic            mem_halt,
  input  logic            ex_dREN,
  input  regbits_t        ex_rt,
  input  regbits_t        id_rs,
  input  regbits_t        id_rt,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_en,
  output logic            idex_flush,
  output logic            exmem_en,
  output logic            exmem_flush,
  output logic            memwb_en,
  output logic            memwb_flush,
  output logic            halted,
  output logic [CNTW-1:0] stall_count,
  output logic            watchdog
);
  localparam int IW = $clog2(TIMEOUT + 1);

  hazard_state_t state, state_nxt;
  logic          loaduse, memreq, dstall;
  logic          ifid_en_raw, idex_en_raw, exmem_en_raw;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [CNTW-1:0] stall_nxt;

  hazard_detect u_hazard_detect (
    .ex_dREN (ex_dREN),
    .ex_rt   (ex_rt),
    .id_rs   (id_rs),
    .id_rt   (id_rt),
    .loaduse (loaduse)
  );

  assign memreq = mem_dREN | mem_dWEN;
  assign dstall = memreq & ~dhit;

  always_comb begin
    state_nxt    = state;
    pc_en        = 1'b0;
    ifid_en_raw  = 1'b0;
    idex_en_raw  = 1'b0;
    exmem_en_raw = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;
    if (state != HALT) begin
      if (mem_halt) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        state_nxt   = HALT;
      end else if (dstall) begin
        state_nxt = DWAIT;
      end else begin
        // dhit arriving in DWAIT falls through here, so the access completes exactly once
        state_nxt = RUN;
        if (mem_redirect) begin
          pc_en       = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_en    = 1'b1;
        end else if (!ihit) begin
          exmem_flush = 1'b1;
          memwb_en    = 1'b1;
        end else if (loaduse) begin
          idex_flush   = 1'b1;
          exmem_en_raw = 1'b1;
          memwb_en     = 1'b1;
        end else begin
          pc_en        = 1'b1;
          ifid_en_raw  = 1'b1;
          idex_en_raw  = 1'b1;
          exmem_en_raw = 1'b1;
          memwb_en     = 1'b1;
        end
      end
    end
  end

  // flush always wins over enable on the same latch
  assign ifid_en  = ifid_en_raw  & ~ifid_flush;
  assign idex_en  = idex_en_raw  & ~idex_flush;
  assign exmem_en = exmem_en_raw & ~exmem_flush;

  always_comb begin
    stall_nxt = stall_count;
    if ((state != HALT) && !pc_en && (stall_count != '1))
      stall_nxt = stall_count + CNTW'(1);
    idle_nxt = idle_cnt;
    if (memwb_en)
      idle_nxt = '0;
    else if ((state != HALT) && (idle_cnt != IW'(TIMEOUT)))
      idle_nxt = idle_cnt + IW'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      halted      <= 1'b0;
      stall_count <= '0;
      idle_cnt    <= '0;
      watchdog    <= 1'b0;
    end else begin
      state       <= state_nxt;
      halted      <= (state_nxt == HALT);
      stall_count <= stall_nxt;
      idle_cnt    <= idle_nxt;
      watchdog    <= watchdog | (idle_nxt == IW'(TIMEOUT));
    end
  end
endmodule

// File: tb/tb_pipeline_control.sv
// Directed-vector bench for pipeline_control with CNTW=3, TIMEOUT=8.
module tb_pipeline_control;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, mem_halt, ex_dREN;
  regbits_t   ex_rt, id_rs, id_rt;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, exmem_flush, memwb_en, memwb_flush, halted, watchdog;
  logic [2:0] stall_count;
  logic [8:0] ctl;

  int checks = 0;
  int errors = 0;

  // ctl order: pc, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl
  localparam logic [8:0] C_NORM  = 9'b1_10_10_10_10;
  localparam logic [8:0] C_LU    = 9'b0_00_01_10_10;
  localparam logic [8:0] C_FRZ   = 9'b0_00_00_00_00;
  localparam logic [8:0] C_REDIR = 9'b1_01_01_01_10;
  localparam logic [8:0] C_NOIH  = 9'b0_00_00_01_10;
  localparam logic [8:0] C_HALT  = 9'b0_01_01_01_10;

  pipeline_control #(.CNTW(3), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_redirect(mem_redirect),
    .mem_halt(mem_halt), .ex_dREN(ex_dREN), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halted(halted), .stall_count(stall_count), .watchdog(watchdog)
  );

  always #5 CLK = ~CLK;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_en, memwb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    mem_redirect = 1'b0; mem_halt = 1'b0; ex_dREN = 1'b0;
    ex_rt = '0; id_rs = '0; id_rt = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    #12;
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_wdog", 32'(watchdog), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'(C_NORM));
    do_reset();

    // load-use on rs, then on rt, then r0 target which must not stall
    ex_dREN = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
    chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    step(1);
    chk("lu_rs_cnt", 32'(stall_count), 32'd1);
    ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7; #1;
    chk("lu_rt_ctl", 32'(ctl), 32'(C_LU));
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
    chk("lu_r0_ctl", 32'(ctl), 32'(C_NORM));
    ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd4; #1;
    chk("lu_nomatch", 32'(ctl), 32'(C_NORM));
    step(1);
    chk("lu_cnt_hold", 32'(stall_count), 32'd1);

    // data wait: three frozen cycles, then dhit resolves as a normal cycle
    do_reset();
    mem_dREN = 1'b1; dhit = 1'b0; #1;
    chk("dw_ctl0", 32'(ctl), 32'(C_FRZ));
    step(1);
    chk("dw_ctl1", 32'(ctl), 32'(C_FRZ));
    step(2);
    chk("dw_cnt3", 32'(stall_count), 32'd3);
    dhit = 1'b1; #1;
    chk("dw_hit_ctl", 32'(ctl), 32'(C_NORM));
    step(1);
    mem_dREN = 1'b0; dhit = 1'b0; #1;
    chk("dw_after_cnt", 32'(stall_count), 32'd3);
    chk("dw_after_ctl", 32'(ctl), 32'(C_NORM));
    mem_dWEN = 1'b1; #1;
    chk("dw_write_ctl", 32'(ctl), 32'(C_FRZ));
    mem_dWEN = 1'b0;

    // redirect beats a missing ifetch; then a bare ifetch miss
    mem_redirect = 1'b1; ihit = 1'b0; #1;
    chk("redir_ctl", 32'(ctl), 32'(C_REDIR));
    mem_redirect = 1'b0; #1;
    chk("noihit_ctl", 32'(ctl), 32'(C_NOIH));
    ex_dREN = 1'b1; ex_rt = 5'd2; id_rs = 5'd2; #1;
    chk("noihit_over_lu", 32'(ctl), 32'(C_NOIH));
    idle_inputs();

    // halt beats redirect; HALT then freezes everything
    do_reset();
    mem_halt = 1'b1; mem_redirect = 1'b1; #1;
    chk("halt_ctl", 32'(ctl), 32'(C_HALT));
    step(1);
    chk("halted", 32'(halted), 32'd1);
    mem_halt = 1'b0; mem_redirect = 1'b0; ihit = 1'b1; #1;
    chk("halt_frozen", 32'(ctl), 32'(C_FRZ));
    mem_halt = 1'b1; step(3);
    chk("halt_stay", 32'(halted), 32'd1);
    chk("halt_cnt", 32'(stall_count), 32'd1);
    chk("halt_ctl2", 32'(ctl), 32'(C_FRZ));
    do_reset();
    chk("halt_exit", 32'(halted), 32'd0);
    chk("halt_exit_ctl", 32'(ctl), 32'(C_NORM));

    // watchdog: ifetch misses still retire MEM, data stalls do not
    ihit = 1'b0; step(10);
    chk("wd_ihit_off", 32'(watchdog), 32'd0);
    chk("wd_ihit_memwb", 32'(memwb_en), 32'd1);
    chk("sat_ihit", 32'(stall_count), 32'd7);
    do_reset();
    mem_dREN = 1'b1; dhit = 1'b0;
    step(7);
    chk("wd_7", 32'(watchdog), 32'd0);
    step(1);
    chk("wd_8", 32'(watchdog), 32'd1);
    dhit = 1'b1; ihit = 1'b1; step(3);
    chk("wd_sticky", 32'(watchdog), 32'd1);

    // saturation at 7, then async reset mid-DWAIT
    do_reset();
    mem_dREN = 1'b1; dhit = 1'b0;
    step(6);
    chk("sat_6", 32'(stall_count), 32'd6);
    step(4);
    chk("sat_10", 32'(stall_count), 32'd7);
    #2 nRST = 1'b0; #1;
    chk("mid_rst_cnt", 32'(stall_count), 32'd0);
    chk("mid_rst_wdog", 32'(watchdog), 32'd0);
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1; #1;
    chk("mid_rst_ctl", 32'(ctl), 32'(C_NORM));
    step(1);
    chk("mid_rst_run", 32'(stall_count), 32'd0);
    chk("memwb_fl0", 32'(memwb_flush), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
